// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map, STATUS bit positions and UART state types
// Imported by gpio_mmio_v2, sync_fifo users and the UART helpers.
package gpio_pkg;

   // Register indices decoded from the 4-bit address
   localparam logic [3:0] REG_LED    = 4'h0;
   localparam logic [3:0] REG_TX     = 4'h1;
   localparam logic [3:0] REG_STATUS = 4'h2;
   localparam logic [3:0] REG_RX     = 4'h3;
   localparam logic [3:0] REG_SW     = 4'h4;
   localparam logic [3:0] REG_EDGE   = 4'h5;
   localparam logic [3:0] REG_RXCNT  = 4'h6;

   // STATUS register bit positions
   localparam int ST_TX_READY   = 0;
   localparam int ST_RX_NONEMPTY = 1;
   localparam int ST_RX_FULL    = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_TX_DROP    = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Ports: clk, rst (async, active-high), push/din, pop/dout (head, combinational),
//        full, empty, count (0..DEPTH).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling
// Ports: clk, rst (async, active-high), rxd (async serial in),
//        rx_byte, rx_byte_ready (1-cycle pulse per valid frame).
module uart_rx import gpio_pkg::*; #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       rx_byte_ready
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rxd_s1, rxd_s2;
   rx_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          done_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_s1        <= 1'b1;
         rxd_s2        <= 1'b1;
         state         <= RX_IDLE;
         cnt           <= '0;
         bit_idx       <= 3'd0;
         shreg         <= 8'h00;
         rx_byte       <= 8'h00;
         rx_byte_ready <= 1'b0;
      end else begin
         rxd_s1        <= rxd;
         rxd_s2        <= rxd_s1;
         state         <= state_n;
         cnt           <= cnt_n;
         bit_idx       <= bit_idx_n;
         shreg         <= shreg_n;
         rx_byte_ready <= done_n;
         if (done_n) rx_byte <= shreg;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      done_n    = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_n = '0;
            if (!rxd_s2) state_n = RX_START;
         end
         RX_START: begin
            // Re-check the line at mid start bit to reject glitches
            if (cnt == HALF_END) begin
               cnt_n     = '0;
               bit_idx_n = 3'd0;
               state_n   = rxd_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_END) begin
               cnt_n   = '0;
               shreg_n = {rxd_s2, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = RX_STOP;
               else                 bit_idx_n = bit_idx + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_END) begin
               cnt_n   = '0;
               state_n = RX_IDLE;
               done_n  = rxd_s2;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter
// Ports: clk, tx_en (1-cycle start), tx_byte, tx_ready (idle), txd (serial out).
// No reset: the all-zero state is idle with the line high, and a frame in flight
// is allowed to complete across a reset of the surrounding block.
module uart_tx import gpio_pkg::*; #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       tx_en,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       txd
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;

   always_ff @(posedge clk) begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      txd       = 1'b1;
      case (state)
         TX_IDLE: begin
            cnt_n = '0;
            if (tx_en) begin
               shreg_n   = tx_byte;
               bit_idx_n = 3'd0;
               state_n   = TX_START;
            end
         end
         TX_START: begin
            txd = 1'b0;
            if (cnt == BIT_END) begin
               cnt_n   = '0;
               state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            txd = shreg[bit_idx];
            if (cnt == BIT_END) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) state_n = TX_STOP;
               else                 bit_idx_n = bit_idx + 1'b1;
            end
         end
         TX_STOP: begin
            txd = 1'b1;
            if (cnt == BIT_END) begin
               cnt_n   = '0;
               state_n = TX_IDLE;
            end
         end
         default: state_n = TX_IDLE;
      endcase
   end

   assign tx_ready = (state == TX_IDLE);

endmodule

// File: rtl/gpio_mmio_v2.sv
// rtl/gpio_mmio_v2.sv - memory-mapped LED/switch/UART peripheral with RX FIFO
// Ports: clk, rst (async, active-high); bus: state, enabled, load_enable,
//        store_enable, address, data_in, data_out (registered load data);
//        led_out, sw (raw switches), uart_txd_in (serial in), uart_rxd_out (serial out).
module gpio_mmio_v2 import gpio_pkg::*; #(
   parameter int N_LED           = 4,
   parameter int N_SW            = 4,
   parameter int RX_DEPTH        = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CLKS_PER_BIT    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       state,
   input  logic             enabled,
   input  logic             load_enable,
   input  logic             store_enable,
   input  logic [3:0]       address,
   input  logic [31:0]      data_in,
   output logic [31:0]      data_out,
   output logic [N_LED-1:0] led_out,
   input  logic [N_SW-1:0]  sw,
   input  logic             uart_txd_in,
   output logic             uart_rxd_out
);

   localparam int CNT_W = $clog2(RX_DEPTH) + 1;
   localparam int DB_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_CW-1:0] DB_MAX = DB_CW'(DEBOUNCE_CYCLES - 1);

   logic acc, wr, rd;
   assign acc = (state == 3'd3) && enabled;
   assign wr  = acc && store_enable;
   assign rd  = acc && load_enable && !store_enable;

   // TX side
   logic       tx_en;
   logic [7:0] tx_byte;
   logic       tx_ready_raw;
   logic       tx_ready;
   logic       tx_drop;

   // The transmitter only goes busy the cycle after tx_en, so mask that gap
   assign tx_ready = tx_ready_raw && !tx_en;

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk      (clk),
      .tx_en    (tx_en),
      .tx_byte  (tx_byte),
      .tx_ready (tx_ready_raw),
      .txd      (uart_rxd_out)
   );

   // RX side
   logic [7:0]       rx_byte;
   logic             rx_byte_ready;
   logic             rx_overrun;
   logic             fifo_pop;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk           (clk),
      .rst           (rst),
      .rxd           (uart_txd_in),
      .rx_byte       (rx_byte),
      .rx_byte_ready (rx_byte_ready)
   );

   assign fifo_pop = rd && (address == REG_RX) && !fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_byte_ready),
      .din   (rx_byte),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Switch synchroniser and per-bit debounce
   logic [N_SW-1:0] sw_s1, sw_s2;
   logic [N_SW-1:0] sw_deb;
   logic [N_SW-1:0] sw_rise;
   logic [N_SW-1:0] sw_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
      end
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_db
      logic [DB_CW-1:0] cnt;
      logic             last;
      logic             deb;
      logic             accept;

      assign accept = (sw_s2[i] == last) && (cnt == DB_MAX);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt  <= '0;
            last <= 1'b0;
            deb  <= 1'b0;
         end else begin
            last <= sw_s2[i];
            if (sw_s2[i] != last) cnt <= '0;
            else if (accept)      deb <= sw_s2[i];
            else                  cnt <= cnt + 1'b1;
         end
      end

      assign sw_deb[i]  = deb;
      assign sw_rise[i] = accept && sw_s2[i] && !deb;
   end

   // Write-side decode
   logic            status_wr;
   logic            drop_set, ovr_set;
   logic [N_SW-1:0] edge_clr;

   assign status_wr = wr && (address == REG_STATUS);
   assign drop_set  = wr && (address == REG_TX) && !tx_ready;
   assign ovr_set   = rx_byte_ready && fifo_full && !fifo_pop;
   assign edge_clr  = (wr && (address == REG_EDGE)) ? data_in[N_SW-1:0] : '0;

   // Read mux
   logic [31:0] rd_data;

   always_comb begin
      rd_data = 32'h0;
      case (address)
         REG_LED:    rd_data[N_LED-1:0] = led_out;
         REG_STATUS: begin
            rd_data[ST_TX_READY]    = tx_ready;
            rd_data[ST_RX_NONEMPTY] = !fifo_empty;
            rd_data[ST_RX_FULL]     = fifo_full;
            rd_data[ST_RX_OVERRUN]  = rx_overrun;
            rd_data[ST_TX_DROP]     = tx_drop;
         end
         REG_RX:     if (!fifo_empty) rd_data[7:0] = fifo_dout;
         REG_SW:     rd_data[N_SW-1:0] = sw_deb;
         REG_EDGE:   rd_data[N_SW-1:0] = sw_edge;
         REG_RXCNT:  rd_data = 32'(fifo_count);
         default:    rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_out    <= '0;
         data_out   <= 32'h0;
         tx_en      <= 1'b0;
         tx_byte    <= 8'h00;
         tx_drop    <= 1'b0;
         rx_overrun <= 1'b0;
         sw_edge    <= '0;
      end else begin
         tx_en <= 1'b0;
         if (wr && (address == REG_LED)) led_out <= data_in[N_LED-1:0];
         if (wr && (address == REG_TX) && tx_ready) begin
            tx_byte <= data_in[7:0];
            tx_en   <= 1'b1;
         end
         // Sticky flags: a set in the same cycle as a W1C clear wins
         tx_drop    <= (tx_drop && !(status_wr && data_in[ST_TX_DROP])) || drop_set;
         rx_overrun <= (rx_overrun && !(status_wr && data_in[ST_RX_OVERRUN])) || ovr_set;
         sw_edge    <= (sw_edge & ~edge_clr) | sw_rise;
         if (rd) data_out <= rd_data;
      end
   end

   logic unused_data;
   assign unused_data = ^data_in;

endmodule

// File: tb/tb_gpio_mmio_v2.sv
// tb/tb_gpio_mmio_v2.sv - self-checking bench for gpio_mmio_v2
module tb_gpio_mmio_v2;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
   localparam int DEB   = 16;

   localparam logic [3:0] A_LED = 4'h0, A_TX = 4'h1, A_STATUS = 4'h2, A_RX = 4'h3;
   localparam logic [3:0] A_SW = 4'h4, A_EDGE = 4'h5, A_RXCNT = 4'h6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  state = 3'd0;
   logic        enabled = 1'b0;
   logic        load_enable = 1'b0;
   logic        store_enable = 1'b0;
   logic [3:0]  address = 4'h0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] data_out;
   logic [3:0]  led_out;
   logic [3:0]  sw = 4'h0;
   logic        uart_txd_in = 1'b1;
   logic        uart_rxd_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [7:0] rxq[$];
   bit         m_ovr  = 0;
   bit         m_drop = 0;
   logic [3:0] m_led  = 4'h0;
   logic [7:0] inject_byte;

   gpio_mmio_v2 dut (
      .clk          (clk),
      .rst          (rst),
      .state        (state),
      .enabled      (enabled),
      .load_enable  (load_enable),
      .store_enable (store_enable),
      .address      (address),
      .data_in      (data_in),
      .data_out     (data_out),
      .led_out      (led_out),
      .sw           (sw),
      .uart_txd_in  (uart_txd_in),
      .uart_rxd_out (uart_rxd_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_status(bit tx_idle);
      logic [31:0] s;
      s = 32'h0;
      s[0] = tx_idle;
      s[1] = (rxq.size() > 0);
      s[2] = (rxq.size() == DEPTH);
      s[3] = m_ovr;
      s[4] = m_drop;
      return s;
   endfunction

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      state = 3'd3; enabled = 1'b1; store_enable = 1'b1; load_enable = 1'b0;
      address = a; data_in = d;
      @(negedge clk);
      state = 3'd0; enabled = 1'b0; store_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      state = 3'd3; enabled = 1'b1; load_enable = 1'b1; store_enable = 1'b0;
      address = a;
      @(negedge clk);
      state = 3'd0; enabled = 1'b0; load_enable = 1'b0;
      d = data_out;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      uart_txd_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_txd_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_txd_in = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   function automatic void model_push(input logic [7:0] b);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else                    m_ovr = 1;
   endfunction

   task automatic test_reset;
      logic [31:0] d;
      repeat (3) @(negedge clk);
      n_checks++; if (led_out !== 4'h0) $display("FAIL reset_led got %h exp 0", led_out); else n_pass++;
      n_checks++; if (data_out !== 32'h0) $display("FAIL reset_data_out got %h exp 0", data_out); else n_pass++;
      n_checks++; if (uart_rxd_out !== 1'b1) $display("FAIL reset_txline got %b exp 1", uart_rxd_out); else n_pass++;
      rst = 1'b0;
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h1) $display("FAIL reset_status got %h exp 1", d); else n_pass++;
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'h0) $display("FAIL reset_rxcount got %h exp 0", d); else n_pass++;
   endtask

   task automatic test_led;
      logic [31:0] d, v;
      bus_write(A_LED, 32'hFFFF_FFF5);
      m_led = 4'h5;
      n_checks++; if (led_out !== 4'b0101) $display("FAIL led_write got %h exp 5", led_out); else n_pass++;
      bus_read(A_LED, d);
      n_checks++; if (d !== 32'h5) $display("FAIL led_read got %h exp 5", d); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         v = $urandom;
         bus_write(A_LED, v);
         m_led = v[3:0];
         bus_read(A_LED, d);
         n_checks++; if (led_out !== m_led) $display("FAIL led_rand_out got %h exp %h", led_out, m_led); else n_pass++;
         n_checks++; if (d !== {28'h0, m_led}) $display("FAIL led_rand_read got %h exp %h", d, {28'h0, m_led}); else n_pass++;
      end
      // Wrong pipeline state: no access
      @(negedge clk);
      state = 3'd2; enabled = 1'b1; store_enable = 1'b1; address = A_LED; data_in = {28'h0, ~m_led};
      @(negedge clk);
      state = 3'd0; enabled = 1'b0; store_enable = 1'b0;
      n_checks++; if (led_out !== m_led) $display("FAIL led_state_gate got %h exp %h", led_out, m_led); else n_pass++;
      // Store has priority over load: write happens, data_out holds
      @(negedge clk);
      state = 3'd3; enabled = 1'b1; store_enable = 1'b1; load_enable = 1'b1;
      address = A_LED; data_in = {28'h0, ~m_led};
      @(negedge clk);
      state = 3'd0; enabled = 1'b0; store_enable = 1'b0; load_enable = 1'b0;
      n_checks++; if (data_out !== {28'h0, m_led}) $display("FAIL store_prio_hold got %h exp %h", data_out, {28'h0, m_led}); else n_pass++;
      m_led = ~m_led;
      n_checks++; if (led_out !== m_led) $display("FAIL store_prio_write got %h exp %h", led_out, m_led); else n_pass++;
      bus_write(4'h9, 32'h0);
      n_checks++; if (led_out !== m_led) $display("FAIL unmapped_write got %h exp %h", led_out, m_led); else n_pass++;
      bus_read(4'h7, d);
      n_checks++; if (d !== 32'h0) $display("FAIL unmapped_read7 got %h exp 0", d); else n_pass++;
      bus_read(4'hF, d);
      n_checks++; if (d !== 32'h0) $display("FAIL unmapped_readF got %h exp 0", d); else n_pass++;
   endtask

   task automatic test_rx_fifo;
      logic [31:0] d, e;
      for (int k = 0; k < 9; k++) begin
         send_byte(8'h10 + 8'(k));
         model_push(8'h10 + 8'(k));
      end
      repeat (10) @(negedge clk);
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'(rxq.size())) $display("FAIL rx_fill_count got %h exp %h", d, rxq.size()); else n_pass++;
      bus_read(A_STATUS, d);
      e = exp_status(1);
      n_checks++; if (d !== e) $display("FAIL rx_fill_status got %h exp %h", d, e); else n_pass++;
      for (int k = 0; k < 9; k++) begin
         bus_read(A_RX, d);
         e = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h0;
         n_checks++; if (d !== e) $display("FAIL rx_read%0d got %h exp %h", k, d, e); else n_pass++;
      end
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'h0) $display("FAIL rx_drain_count got %h exp 0", d); else n_pass++;
      bus_write(A_STATUS, 32'h8);
      m_ovr = 0;
      bus_read(A_STATUS, d);
      e = exp_status(1);
      n_checks++; if (d !== e) $display("FAIL rx_ovr_clear got %h exp %h", d, e); else n_pass++;
   endtask

   task automatic test_tx;
      logic [31:0] st_busy, d, e;
      logic [7:0]  cap;
      bit          cap_ok;
      int          en_cnt;
      bit          idle;
      cap_ok = 0; en_cnt = 0; cap = 8'h00;
      fork
         begin
            repeat (CPB * 14) begin
               @(negedge clk);
               if (dut.tx_en) en_cnt++;
            end
         end
         begin
            for (int t = 0; t < CPB * 4; t++) begin
               @(negedge clk);
               if (uart_rxd_out === 1'b0) begin
                  cap_ok = 1;
                  break;
               end
            end
            if (cap_ok) begin
               repeat (CPB / 2) @(negedge clk);
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  cap[i] = uart_rxd_out;
               end
            end
         end
         begin
            bus_write(A_TX, 32'h41);
            bus_write(A_TX, 32'h42);
            m_drop = 1;
            bus_read(A_STATUS, st_busy);
         end
      join
      e = exp_status(0);
      n_checks++; if (st_busy !== e) $display("FAIL tx_busy_status got %h exp %h", st_busy, e); else n_pass++;
      n_checks++; if (cap_ok !== 1'b1) $display("FAIL tx_start_seen got %b exp 1", cap_ok); else n_pass++;
      n_checks++; if (cap !== 8'h41) $display("FAIL tx_byte got %h exp 41", cap); else n_pass++;
      n_checks++; if (en_cnt != 1) $display("FAIL tx_en_pulses got %0d exp 1", en_cnt); else n_pass++;
      idle = 0;
      for (int t = 0; t < 20; t++) begin
         bus_read(A_STATUS, d);
         if (d[0]) begin
            idle = 1;
            break;
         end
      end
      n_checks++; if (idle !== 1'b1) $display("FAIL tx_idle_timeout got %b exp 1", idle); else n_pass++;
      e = exp_status(1);
      n_checks++; if (d !== e) $display("FAIL tx_drop_sticky got %h exp %h", d, e); else n_pass++;
      bus_write(A_STATUS, 32'h10);
      m_drop = 0;
      bus_read(A_STATUS, d);
      e = exp_status(1);
      n_checks++; if (d !== e) $display("FAIL tx_drop_clear got %h exp %h", d, e); else n_pass++;
   endtask

   task automatic test_debounce;
      logic [31:0] d;
      logic [3:0]  v;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         sw[2] = ~sw[2];
         if (k < 12) repeat (4) @(negedge clk);
      end
      // sw[2] never stayed put for DEB cycles
      bus_read(A_SW, d);
      n_checks++; if (d !== 32'h0) $display("FAIL db_toggle_sw got %h exp 0", d); else n_pass++;
      bus_read(A_EDGE, d);
      n_checks++; if (d !== 32'h0) $display("FAIL db_toggle_edge got %h exp 0", d); else n_pass++;
      repeat (16) @(negedge clk);
      bus_read(A_SW, d);
      n_checks++; if (d !== 32'h4) $display("FAIL db_hold_sw got %h exp 4", d); else n_pass++;
      bus_read(A_EDGE, d);
      n_checks++; if (d !== 32'h4) $display("FAIL db_hold_edge got %h exp 4", d); else n_pass++;
      bus_write(A_EDGE, 32'h4);
      bus_read(A_EDGE, d);
      n_checks++; if (d !== 32'h0) $display("FAIL db_edge_clear got %h exp 0", d); else n_pass++;
      sw[2] = 1'b0;
      repeat (DEB + 8) @(negedge clk);
      bus_read(A_SW, d);
      n_checks++; if (d !== 32'h0) $display("FAIL db_release_sw got %h exp 0", d); else n_pass++;
      bus_read(A_EDGE, d);
      n_checks++; if (d !== 32'h0) $display("FAIL db_fall_noedge got %h exp 0", d); else n_pass++;
      v = 4'($urandom_range(1, 15));
      sw = v;
      repeat (DEB + 8) @(negedge clk);
      bus_read(A_SW, d);
      n_checks++; if (d !== {28'h0, v}) $display("FAIL db_rand_sw got %h exp %h", d, v); else n_pass++;
      bus_read(A_EDGE, d);
      n_checks++; if (d !== {28'h0, v}) $display("FAIL db_rand_edge got %h exp %h", d, v); else n_pass++;
      bus_write(A_EDGE, 32'hF);
   endtask

   task automatic test_push_pop;
      logic [31:0] d, e;
      logic [7:0]  b;
      bit          got;
      for (int k = 0; k < DEPTH; k++) begin
         b = 8'($urandom);
         send_byte(b);
         model_push(b);
      end
      repeat (10) @(negedge clk);
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'(DEPTH)) $display("FAIL pp_full_count got %h exp %h", d, DEPTH); else n_pass++;
      inject_byte = 8'($urandom);
      fork
         send_byte(inject_byte);
      join_none
      got = 0;
      for (int t = 0; t < CPB * 14; t++) begin
         @(posedge clk);
         #1;
         if (dut.rx_byte_ready === 1'b1) begin
            got = 1;
            break;
         end
      end
      n_checks++; if (got !== 1'b1) $display("FAIL pp_push_timeout got %b exp 1", got); else n_pass++;
      if (got) begin
         state = 3'd3; enabled = 1'b1; load_enable = 1'b1; address = A_RX;
         @(posedge clk);
         #1;
         state = 3'd0; enabled = 1'b0; load_enable = 1'b0;
         e = {24'h0, rxq.pop_front()};
         rxq.push_back(inject_byte);
         n_checks++; if (data_out !== e) $display("FAIL pp_pop_data got %h exp %h", data_out, e); else n_pass++;
      end
      repeat (2 * CPB) @(negedge clk);
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'(rxq.size())) $display("FAIL pp_count got %h exp %h", d, rxq.size()); else n_pass++;
      bus_read(A_STATUS, d);
      e = exp_status(1);
      n_checks++; if (d !== e) $display("FAIL pp_status got %h exp %h", d, e); else n_pass++;
      while (rxq.size() > 0) begin
         bus_read(A_RX, d);
         e = {24'h0, rxq.pop_front()};
         n_checks++; if (d !== e) $display("FAIL pp_order got %h exp %h", d, e); else n_pass++;
      end
   endtask

   task automatic test_reset_midrun;
      logic [31:0] d;
      send_byte(8'h5A);
      bus_write(A_LED, 32'hA);
      bus_read(A_LED, d);
      n_checks++; if (d !== 32'hA) $display("FAIL pre_reset_read got %h exp a", d); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (led_out !== 4'h0) $display("FAIL midrst_led got %h exp 0", led_out); else n_pass++;
      n_checks++; if (data_out !== 32'h0) $display("FAIL midrst_data_out got %h exp 0", data_out); else n_pass++;
      rst = 1'b0;
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h1) $display("FAIL midrst_status got %h exp 1", d); else n_pass++;
      bus_read(A_RXCNT, d);
      n_checks++; if (d !== 32'h0) $display("FAIL midrst_rxcount got %h exp 0", d); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_led;
      test_rx_fifo;
      test_tx;
      test_debounce;
      test_push_pop;
      test_reset_midrun;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpio_mmio_v2.md
Name: gpio_mmio_v2

Overview:
- Parametrised successor to the CPU-facing memory-mapped GPIO/UART peripheral.
- Provides N_LED output bits, N_SW debounced switch inputs with sticky rising-edge flags, a UART transmit port, and a UART receive path buffered by an RX FIFO.
- The core accesses it in memory stage state 3 through the existing load/store strobes.
- Instantiates the existing uart_rx and uart_tx modules.

Parameters:
N_LED, 4, number of LED outputs (1..32)
N_SW, 4, number of switch inputs (1..32)
RX_DEPTH, 8, RX FIFO entries (power of two, >=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a switch value is accepted (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
state  in  3  core pipeline state; accesses act only when state==3'd3
enabled  in  1  address decode select for this peripheral
load_enable  in  1  load access
store_enable  in  1  store access; has priority over load_enable
address  in  4  register index
data_in  in  32  store data
data_out  out  32  registered load data
led_out  out  N_LED  LED drive
sw  in  N_SW  raw asynchronous switch inputs
uart_txd_in  in  1  serial receive line, to uart_rx
uart_rxd_out  out  1  serial transmit line, from uart_tx

Behaviour:
- Reset (async, rst=1): led_out=0, data_out=0, tx_en=0, tx_byte=0, FIFO empty, overrun=0, debounced sw=0, edge flags=0, sync FFs=0.
- Access strobe acc = (state==3'd3) && enabled; wr = acc && store_enable; rd = acc && load_enable && !store_enable.
- Register map, indexed by address:
  - 0x0 LED, R/W: led_out <= data_in[N_LED-1:0]; read returns zero-extended led.
  - 0x1 TX_DATA, W: if tx_ready, load tx_byte <= data_in[7:0] and pulse tx_en high for exactly 1 cycle; if !tx_ready, drop the byte and set tx_drop sticky.
  - 0x2 STATUS, R: bit0 tx_ready, bit1 rx_nonempty, bit2 rx_full, bit3 rx_overrun, bit4 tx_drop; other bits 0.
  - 0x2 STATUS, W: write-1-clear on bits 3 and 4.
  - 0x3 RX_DATA, R: returns {24'b0, FIFO head} and pops the FIFO in the strobe cycle; when the FIFO is empty, returns 0 and does not pop.
  - 0x4 SW, R: debounced switch vector, zero-extended.
  - 0x5 SW_EDGE, R: sticky rising-edge flags of the debounced switches.
  - 0x5 SW_EDGE, W: write-1-clear.
  - 0x6 RX_COUNT, R: FIFO occupancy, 0..RX_DEPTH.
  - Unmapped reads return 0. Unmapped writes have no effect.
- Load latency: data_out updates on the clock edge ending the rd cycle. It holds its value until the next rd.
- A strobe asserted on consecutive cycles is a separate access each cycle; each RX_DATA read cycle pops one entry.
- RX push: each 1-cycle rx_byte_ready pulse pushes rx_byte.
  - Full with no pop in the same cycle: drop the byte and set rx_overrun.
  - Full with a pop in the same cycle: the push succeeds and occupancy stays RX_DEPTH.
- FIFO pointers are log2(RX_DEPTH) bits and wrap. Full/empty are derived from a separate count of width log2(RX_DEPTH)+1.
- Switch path:
  - 2-FF synchroniser per bit.
  - Per-bit counter resets on any change of the synchronised value.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a stable input, the debounced bit takes the synchronised value.
  - A 0->1 transition of a debounced bit sets its edge flag.
- Edge flag set and W1C clear in the same cycle: set wins.
- Overrun or drop set and W1C clear in the same cycle: set wins.
- Reset mid-transmit: uart_tx is not reset by this block. tx_en is held 0 during and after reset until a new write.

Decomposition:
- Shared package gpio_pkg holds:
  - register index constants REG_LED, REG_TX, REG_STATUS, REG_RX, REG_SW, REG_EDGE, REG_RXCNT;
  - STATUS bit position constants.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH): push/pop/full/empty/count, asynchronous active-high reset.
- Debouncer is inline generate logic.

Test Plan:
- Reset checks: assert rst mid-run -> led_out=0, data_out=0, STATUS read returns 0x1 with the UART idle, RX_COUNT=0.
- LED write with N_LED=4: write 0xFFFF_FFF5 to 0x0 -> led_out=4'b0101; read back 0x0 -> data_out=0x0000_0005 one cycle after the strobe.
- RX FIFO fill and overrun:
  - Inject 9 serial bytes 0x10..0x18 with RX_DEPTH=8 -> RX_COUNT=8 and STATUS bits 2 and 3 set.
  - Eight RX_DATA reads return 0x10..0x17; the ninth read returns 0 with no pop.
  - Write 0x8 to STATUS -> bit3 clears.
- TX handshake:
  - Write 0x41 to 0x1 while tx_ready=1 -> tx_en high exactly 1 cycle and 'A' appears on uart_rxd_out.
  - A second write while busy -> dropped and tx_drop set.
- Debounce with DEBOUNCE_CYCLES=16:
  - Toggle sw[2] every 5 cycles -> SW stays 0.
  - Hold sw[2] high for 20 cycles -> SW=0x4 and SW_EDGE=0x4.
  - Write 0x4 to 0x5 -> SW_EDGE=0.
- Simultaneous push and pop: with the FIFO full, an rx_byte_ready pulse coincides with an RX_DATA read -> RX_COUNT stays 8, no overrun, FIFO order preserved.
